// File: rtl/flash_seq.sv
// flash_seq: LED flash sequencer for the alarm path of the digital clock.
// A start emits a burst of timed flashes; loop mode repeats bursts after a pause.
module flash_seq #(
  parameter int TW     = 8,
  parameter int NW     = 4,
  parameter bit RETRIG = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [TW-1:0] cfg_on,
  input  logic [TW-1:0] cfg_off,
  input  logic [TW-1:0] cfg_gap,
  input  logic [NW-1:0] cfg_cnt,
  input  logic          cfg_loop,
  output logic          out,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] flash_idx
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLASH = 2'd1,
    S_SPACE = 2'd2,
    S_PAUSE = 2'd3
  } state_e;

  localparam logic [TW-1:0] T_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] T_ONE  = {{(TW-1){1'b0}}, 1'b1};
  localparam logic [NW-1:0] N_ZERO = {NW{1'b0}};
  localparam logic [NW-1:0] N_ONE  = {{(NW-1){1'b0}}, 1'b1};

  // A programmed zero behaves as one so every phase lasts at least a cycle.
  function automatic logic [TW-1:0] eff_t(input logic [TW-1:0] x);
    return (x == T_ZERO) ? T_ONE : x;
  endfunction

  function automatic logic [NW-1:0] eff_n(input logic [NW-1:0] x);
    return (x == N_ZERO) ? N_ONE : x;
  endfunction

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] on_q, on_d;
  logic [TW-1:0] off_q, off_d;
  logic [TW-1:0] gap_q, gap_d;
  logic [NW-1:0] ncfg_q, ncfg_d;
  logic          loop_q, loop_d;

  logic          done_s;
  logic          abort_s;
  logic          load_s;
  logic          last_flash_s;
  logic          natural_end_s;
  logic [NW-1:0] last_idx_s;

  assign last_idx_s    = eff_n(ncfg_q) - N_ONE;
  assign last_flash_s  = (state_q == S_FLASH) && (timer_q == T_ZERO) && !(cnt_q < last_idx_s);
  assign natural_end_s = last_flash_s && !loop_q;
  assign abort_s       = (state_q != S_IDLE) && stop;
  // A busy start only counts when retriggering is enabled; stop always wins.
  assign load_s        = start && !stop && ((state_q == S_IDLE) || RETRIG);

  // Next-state, timer, counter and config-latch logic.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    on_d    = on_q;
    off_d   = off_q;
    gap_d   = gap_q;
    ncfg_d  = ncfg_q;
    loop_d  = loop_q;
    done_s  = 1'b0;

    if (abort_s) begin
      state_d = S_IDLE;
      timer_d = T_ZERO;
      cnt_d   = N_ZERO;
    end else if (load_s) begin
      on_d    = cfg_on;
      off_d   = cfg_off;
      gap_d   = cfg_gap;
      ncfg_d  = cfg_cnt;
      loop_d  = cfg_loop;
      timer_d = eff_t(cfg_on) - T_ONE;
      cnt_d   = N_ZERO;
      state_d = S_FLASH;
      done_s  = natural_end_s;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_FLASH: begin
          if (timer_q != T_ZERO) begin
            timer_d = timer_q - T_ONE;
          end else if (cnt_q < last_idx_s) begin
            state_d = S_SPACE;
            timer_d = eff_t(off_q) - T_ONE;
          end else if (loop_q) begin
            state_d = S_PAUSE;
            timer_d = eff_t(gap_q) - T_ONE;
          end else begin
            state_d = S_IDLE;
            timer_d = T_ZERO;
            cnt_d   = N_ZERO;
            done_s  = 1'b1;
          end
        end
        S_SPACE: begin
          if (timer_q != T_ZERO) begin
            timer_d = timer_q - T_ONE;
          end else begin
            state_d = S_FLASH;
            timer_d = eff_t(on_q) - T_ONE;
            cnt_d   = cnt_q + N_ONE;
          end
        end
        S_PAUSE: begin
          if (timer_q != T_ZERO) begin
            timer_d = timer_q - T_ONE;
          end else begin
            state_d = S_FLASH;
            timer_d = eff_t(on_q) - T_ONE;
            cnt_d   = N_ZERO;
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = T_ZERO;
          cnt_d   = N_ZERO;
        end
      endcase
    end
  end

  // State, counter and latched-config registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= T_ZERO;
      cnt_q   <= N_ZERO;
      on_q    <= T_ZERO;
      off_q   <= T_ZERO;
      gap_q   <= T_ZERO;
      ncfg_q  <= N_ZERO;
      loop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      on_q    <= on_d;
      off_q   <= off_d;
      gap_q   <= gap_d;
      ncfg_q  <= ncfg_d;
      loop_q  <= loop_d;
    end
  end

  assign out       = (state_q == S_FLASH);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_s;
  assign flash_idx = (state_q == S_IDLE) ? N_ZERO : cnt_q;

endmodule

// File: tb/tb_flash_seq.sv
// Scoreboard bench for flash_seq: two instances (RETRIG=0 and RETRIG=1) share stimulus;
// expected per-cycle outputs are queued per instance and checked by a monitor at negedge.
module tb_flash_seq;

  logic       clk = 1'b0;
  logic       rst, start, stop, cfg_loop;
  logic [7:0] cfg_on, cfg_off, cfg_gap;
  logic [3:0] cfg_cnt;
  logic       out0, busy0, done0, out1, busy1, done1;
  logic [3:0] idx0, idx1;

  always #5 clk = ~clk;

  flash_seq #(.TW(8), .NW(4), .RETRIG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_gap(cfg_gap), .cfg_cnt(cfg_cnt),
    .cfg_loop(cfg_loop), .out(out0), .busy(busy0), .done(done0), .flash_idx(idx0)
  );

  flash_seq #(.TW(8), .NW(4), .RETRIG(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_gap(cfg_gap), .cfg_cnt(cfg_cnt),
    .cfg_loop(cfg_loop), .out(out1), .busy(busy1), .done(done1), .flash_idx(idx1)
  );

  typedef struct {
    int         cyc;
    logic       o;
    logic       b;
    logic       d;
    logic [3:0] idx;
    string      name;
  } exp_t;

  exp_t  q0[$];
  exp_t  q1[$];
  int    cyc   = 0;
  int    base  = 0;
  int    total = 0;
  int    bad   = 0;
  string tname = "init";

  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp1(input int id, input int off, input logic o, input logic b,
                      input logic d, input int idx);
    exp_t e;
    e.cyc = base + off; e.o = o; e.b = b; e.d = d; e.idx = 4'(idx); e.name = tname;
    if (id == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic exp_both(input int off, input logic o, input logic b, input logic d,
                          input int idx);
    exp1(0, off, o, b, d, idx);
    exp1(1, off, o, b, d, idx);
  endtask

  task automatic idle_exp(input int id, input int off, input int n);
    for (int i = 0; i < n; i++) exp1(id, off + i, 1'b0, 1'b0, 1'b0, 0);
  endtask

  // Hand-shaped burst: n flashes of `on` cycles separated by `sp` cycles, done on the last flash cycle.
  task automatic burst_exp(input int id, input int s, input int on, input int sp,
                           input int n, input int lim);
    int o;
    for (int k = 0; k < n; k++) begin
      for (int t = 0; t < on; t++) begin
        o = s + k * (on + sp) + t;
        if (o < lim) exp1(id, o, 1'b1, 1'b1, (k == n - 1) && (t == on - 1), k);
      end
      if (k < n - 1) begin
        for (int t = 0; t < sp; t++) begin
          o = s + k * (on + sp) + on + t;
          if (o < lim) exp1(id, o, 1'b0, 1'b1, 1'b0, k);
        end
      end
    end
  endtask

  task automatic check(input int id, input exp_t e, input logic o, input logic b,
                       input logic d, input logic [3:0] idx);
    total++;
    if (e.cyc != cyc || {o, b, d, idx} !== {e.o, e.b, e.d, e.idx}) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d(exp cyc %0d) got out=%b busy=%b done=%b idx=%0d want out=%b busy=%b done=%b idx=%0d",
               e.name, id, cyc - base, e.cyc - base, o, b, d, idx, e.o, e.b, e.d, e.idx);
    end
  endtask

  // Monitor: compare every queued expectation belonging to the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q0.size() > 0 && q0[0].cyc <= cyc) begin
      e = q0.pop_front();
      check(0, e, out0, busy0, done0, idx0);
    end
    while (q1.size() > 0 && q1[0].cyc <= cyc) begin
      e = q1.pop_front();
      check(1, e, out1, busy1, done1, idx1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic begin_test(input string n);
    tname = n;
    base  = cyc;
  endtask

  task automatic set_cfg(input int on, input int off, input int gap, input int n,
                         input logic lp);
    cfg_on = 8'(on); cfg_off = 8'(off); cfg_gap = 8'(gap); cfg_cnt = 4'(n); cfg_loop = lp;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    set_cfg(0, 0, 0, 0, 1'b0);
    run(3);
    rst = 1'b0;
    tick();

    // Reset held three cycles in the middle of a long flash
    begin_test("reset_mid_flash");
    set_cfg(10, 1, 1, 1, 1'b0);
    exp_both(0, 1'b0, 1'b0, 1'b0, 0);
    exp_both(1, 1'b1, 1'b1, 1'b0, 0);
    exp_both(2, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 3; i <= 8; i++) exp_both(i, 1'b0, 1'b0, 1'b0, 0);
    do_start();
    tick();
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(4);

    // Basic burst: on=3 off=2 cnt=3 -> flashes at 1-3, 6-8, 11-13, done at 13
    begin_test("basic_burst");
    set_cfg(3, 2, 0, 3, 1'b0);
    for (int id = 0; id < 2; id++) begin
      idle_exp(id, 0, 1);
      burst_exp(id, 1, 3, 2, 3, 1000);
      idle_exp(id, 14, 2);
    end
    do_start();
    run(15);

    // All-zero fields: one single-cycle flash with done in the same cycle
    begin_test("zero_fields");
    set_cfg(0, 0, 0, 0, 1'b0);
    exp_both(0, 1'b0, 1'b0, 1'b0, 0);
    exp_both(1, 1'b1, 1'b1, 1'b1, 0);
    exp_both(2, 1'b0, 1'b0, 1'b0, 0);
    exp_both(3, 1'b0, 1'b0, 1'b0, 0);
    do_start();
    run(3);

    // Loop mode: 11 0 11 0000 repeating; stop during the second pause
    begin_test("loop_stop");
    set_cfg(2, 1, 4, 2, 1'b1);
    exp_both(0, 1'b0, 1'b0, 1'b0, 0);
    for (int p = 0; p < 2; p++) begin
      exp_both(1 + 9 * p, 1'b1, 1'b1, 1'b0, 0);
      exp_both(2 + 9 * p, 1'b1, 1'b1, 1'b0, 0);
      exp_both(3 + 9 * p, 1'b0, 1'b1, 1'b0, 0);
      exp_both(4 + 9 * p, 1'b1, 1'b1, 1'b0, 1);
      exp_both(5 + 9 * p, 1'b1, 1'b1, 1'b0, 1);
      for (int g = 6; g <= 9; g++) begin
        if (g + 9 * p <= 16) exp_both(g + 9 * p, 1'b0, 1'b1, 1'b0, 1);
      end
    end
    for (int i = 17; i <= 19; i++) exp_both(i, 1'b0, 1'b0, 1'b0, 0);
    do_start();
    run(15);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    run(3);

    // Second start during the idx=2 space: restart only on the RETRIG=1 instance
    begin_test("retrigger");
    set_cfg(2, 2, 0, 4, 1'b0);
    idle_exp(0, 0, 1);
    burst_exp(0, 1, 2, 2, 4, 1000);
    idle_exp(0, 15, 13);
    idle_exp(1, 0, 1);
    burst_exp(1, 1, 2, 2, 4, 12);
    burst_exp(1, 12, 2, 2, 4, 1000);
    idle_exp(1, 26, 2);
    do_start();
    run(10);
    do_start();
    run(16);

    // Start on the done cycle: RETRIG=1 pulses done and flashes on without a gap
    begin_test("done_start");
    set_cfg(2, 1, 0, 1, 1'b0);
    idle_exp(0, 0, 1);
    burst_exp(0, 1, 2, 1, 1, 1000);
    idle_exp(0, 3, 4);
    idle_exp(1, 0, 1);
    burst_exp(1, 1, 2, 1, 1, 1000);
    burst_exp(1, 3, 2, 1, 1, 1000);
    idle_exp(1, 5, 2);
    do_start();
    tick();
    do_start();
    run(4);

    // Config changed mid-burst must not alter the running burst
    begin_test("cfg_isolation");
    set_cfg(3, 1, 0, 2, 1'b0);
    for (int id = 0; id < 2; id++) begin
      idle_exp(id, 0, 1);
      burst_exp(id, 1, 3, 1, 2, 1000);
      idle_exp(id, 8, 2);
    end
    do_start();
    set_cfg(7, 9, 3, 5, 1'b1);
    run(9);

    // start and stop together while idle: nothing starts
    begin_test("start_stop_idle");
    set_cfg(2, 1, 0, 2, 1'b0);
    for (int i = 0; i <= 3; i++) exp_both(i, 1'b0, 1'b0, 1'b0, 0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    run(3);

    // Maximum flash count: 15 flashes, index reaches 14 with no wrap
    begin_test("max_count");
    set_cfg(1, 1, 0, 15, 1'b0);
    for (int id = 0; id < 2; id++) begin
      idle_exp(id, 0, 1);
      burst_exp(id, 1, 1, 1, 15, 1000);
      idle_exp(id, 30, 2);
    end
    do_start();
    run(31);

    // Maximum on time: 255 cycles high, done on the last one
    begin_test("max_on");
    set_cfg(255, 1, 0, 1, 1'b0);
    for (int id = 0; id < 2; id++) begin
      idle_exp(id, 0, 1);
      burst_exp(id, 1, 255, 1, 1, 1000);
      idle_exp(id, 256, 2);
    end
    do_start();
    run(257);

    run(2);
    if (q0.size() != 0 || q1.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: left=%0d required=0", q0.size() + q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flash_seq.md
Name: flash_seq

Overview:
- Parametrised LED flash sequencer for the alarm path of the digital clock.
- On a start pulse it emits a burst of N flashes with runtime-programmable on time, off time and flash count.
- Optional continuous (loop) mode repeats the burst after a programmable pause.
- Supports abort (stop), an optional retrigger mode, and status outputs (busy, done, flash index) for the alarm controller.

Parameters:
- TW, 8, width of the on/off/gap duration fields and of the internal cycle timer.
- NW, 4, width of the flash-count field and of the flash counter.
- RETRIG, 0, 1 = a start while busy restarts the sequence; 0 = a start while busy is ignored.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a sequence.
- stop  in  1  abort request; sampled every cycle.
- cfg_on  in  TW  flash on time in cycles (0 is treated as 1).
- cfg_off  in  TW  space time between flashes in cycles (0 is treated as 1).
- cfg_gap  in  TW  pause between bursts in loop mode, in cycles (0 is treated as 1).
- cfg_cnt  in  NW  flashes per burst (0 is treated as 1).
- cfg_loop  in  1  1 = repeat bursts until stop.
- out  out  1  LED drive; 1 only while in state FLASH.
- busy  out  1  1 whenever state is not IDLE.
- done  out  1  one-cycle pulse at the natural end of a non-loop sequence.
- flash_idx  out  NW  index of the current flash within the burst, 0-based; 0 in IDLE.

Behaviour:
- Reset and clock: clk is the single clock. rst is synchronous, active-high and overrides every other input.
- On the rst edge: state=IDLE, timer=0, flash counter=0, latched config=0, out=0, busy=0, done=0, flash_idx=0.
- States: IDLE, FLASH, SPACE, PAUSE. out, busy and flash_idx are Moore outputs decoded from state and registers. done is a Mealy pulse.
- Config latch: cfg_* are captured into internal registers on an accepted start. Later changes to cfg_* have no effect until the next accepted start.
- IDLE: if start=1 and stop=0, latch config, timer<=eff_on-1, flash counter<=0, next state FLASH. out rises the cycle after start is sampled (latency 1).
- FLASH: out=1 for exactly eff_on cycles, with the timer decrementing to 0.
  - At timer==0, if flash counter < eff_cnt-1: go to SPACE with timer<=eff_off-1.
  - Otherwise, if loop: go to PAUSE with timer<=eff_gap-1.
  - Otherwise: go to IDLE and assert done=1 in this same cycle.
- SPACE: out=0 for exactly eff_off cycles. At timer==0: flash counter+1, timer<=eff_on-1, go to FLASH.
- PAUSE: out=0 for eff_gap cycles. At timer==0: flash counter<=0, timer<=eff_on-1, go to FLASH.
- No SPACE follows the final flash of a burst.
- Effective values: eff_x = (x==0) ? 1 : x. Timer arithmetic is unsigned TW-bit. A maximum value of 2^TW-1 gives exactly 2^TW-1 cycles. The timer never wraps.
- Flash counter: NW-bit. eff_cnt = 2^NW-1 runs all flashes with no wrap. flash_idx = flash counter.
- Stop: in any non-IDLE state, stop=1 forces next state IDLE. out=0 and busy=0 from the next cycle. done is not asserted and counters clear.
- stop and start in the same cycle: stop wins and no sequence starts.
- Start while busy:
  - RETRIG=0: ignored.
  - RETRIG=1: re-latch config, flash counter<=0, timer<=eff_on-1, next state FLASH. If already in FLASH, out stays high continuously.
- done and start in the same cycle (last FLASH cycle): with RETRIG=1 the restart is taken, done is still pulsed, and next state is FLASH. With RETRIG=0 the start is ignored.
- Illegal state encoding: recovers to IDLE on the next clock.

Test Plan:
- Reset and idle: hold rst 3 cycles mid-FLASH -> out=0, busy=0, flash_idx=0, done=0 the cycle after the rst edge; stays idle with start=0.
- Basic burst: cfg_on=3, cfg_off=2, cfg_cnt=3, loop=0, start at cycle 0 -> out high on cycles 1-3, 6-8 and 11-13; flash_idx 0/1/2; done=1 on cycle 13; busy low from cycle 14.
- Zero fields: all cfg_*=0, start -> a single 1-cycle flash, done in that same cycle, busy for 1 cycle.
- Loop plus stop: cfg_on=2, cfg_off=1, cfg_cnt=2, cfg_gap=4, loop=1 -> pattern 11 0 11 0000 repeats and done never fires. Stop asserted during the 2nd PAUSE -> out=0 and busy=0 the next cycle, no done.
- Retrigger: RETRIG=1, cfg_cnt=4, start again during flash_idx=2 SPACE -> FLASH next cycle with flash_idx=0 and a full 4-flash burst. Same stimulus with RETRIG=0 -> the second start has no effect.
- Config isolation and collision: change cfg_on mid-burst -> burst timing unchanged. start and stop in the same IDLE cycle -> stays IDLE.
